// File: rtl/scanline_span_filler.sv
// scanline_span_filler: turns one rasterizer span (row y, edges xa/xb)
// into a left-to-right stream of framebuffer pixel writes.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   span_valid    - span on span_y/xa/xb/color is valid (held until accepted)
//   span_ready    - high in IDLE; span accepted on span_valid && span_ready
//   span_y        - scanline row
//   span_xa       - x position from the short edge
//   span_xb       - x position from the long edge
//   span_color    - fill colour for the whole span
//   px_valid      - pixel write valid (FILL state)
//   px_ready      - framebuffer accepts the pixel
//   px_x, px_y    - pixel coordinates
//   px_addr       - linear framebuffer address y*HRES + x
//   px_color      - pixel colour
//   span_done     - one-cycle pulse after the last pixel (or an empty span)
//   busy          - high while in SETUP or FILL
module scanline_span_filler #(
    parameter int HRES = 320,
    parameter int VRES = 200,
    parameter int XW   = 9,
    parameter int YW   = 8,
    parameter int CW   = 8,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          span_valid,
    output logic          span_ready,
    input  logic [YW-1:0] span_y,
    input  logic [XW-1:0] span_xa,
    input  logic [XW-1:0] span_xb,
    input  logic [CW-1:0] span_color,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic [AW-1:0] px_addr,
    output logic [CW-1:0] px_color,
    output logic          span_done,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;

    localparam logic [XW-1:0] X_MAX = XW'(HRES - 1);
    localparam logic [YW:0]   Y_LIM = (YW + 1)'(VRES);
    localparam logic [AW-1:0] H_MUL = AW'(HRES);

    logic [1:0]    state;
    logic [YW-1:0] y_q;
    logic [XW-1:0] xa_q;
    logic [XW-1:0] xb_q;
    logic [XW-1:0] x_q;
    logic [XW-1:0] hi_q;
    logic [CW-1:0] color_q;
    logic [AW-1:0] addr_q;
    logic          done_q;

    logic [XW-1:0] lo;
    logic [XW-1:0] hi_raw;
    logic [XW-1:0] hi_clip;
    logic [AW-1:0] base;
    logic          empty;

    always_comb begin
        lo      = (xa_q < xb_q) ? xa_q : xb_q;
        hi_raw  = (xa_q < xb_q) ? xb_q : xa_q;
        hi_clip = (hi_raw > X_MAX) ? X_MAX : hi_raw;
        // y*HRES as a sum of shifted copies of y, one per set bit of HRES
        // (for 320 this reduces to (y<<8)+(y<<6)).
        base = '0;
        for (int i = 0; i < AW; i++) begin
            if (H_MUL[i]) begin
                base = base + (AW'(y_q) << i);
            end
        end
        // Rows past the bottom, or spans lying wholly right of the
        // screen, produce no pixels at all.
        empty = ({1'b0, y_q} >= Y_LIM) || (lo > X_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            y_q     <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            x_q     <= '0;
            hi_q    <= '0;
            color_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (span_valid) begin
                        y_q     <= span_y;
                        xa_q    <= span_xa;
                        xb_q    <= span_xb;
                        color_q <= span_color;
                        state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (empty) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        x_q    <= lo;
                        hi_q   <= hi_clip;
                        addr_q <= base + AW'(lo);
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (px_ready) begin
                        if (x_q == hi_q) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            x_q    <= x_q + XW'(1);
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign span_ready = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign px_valid   = (state == S_FILL);
    assign px_x       = x_q;
    assign px_y       = y_q;
    assign px_addr    = addr_q;
    assign px_color   = color_q;
    assign span_done  = done_q;

endmodule

// File: tb/tb_scanline_span_filler.sv
// Directed bench for scanline_span_filler: reset state, basic fill,
// swapped edges, clipping, empty spans, backpressure, back-to-back, reset abort.
module tb_scanline_span_filler;

    logic        clk = 1'b0;
    logic        rst;
    logic        span_valid;
    logic        span_ready;
    logic [7:0]  span_y;
    logic [8:0]  span_xa;
    logic [8:0]  span_xb;
    logic [7:0]  span_color;
    logic        px_valid;
    logic        px_ready;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [15:0] px_addr;
    logic [7:0]  px_color;
    logic        span_done;
    logic        busy;

    int total;
    int bad;
    int cyc = 0;

    scanline_span_filler dut (
        .clk        (clk),
        .rst        (rst),
        .span_valid (span_valid),
        .span_ready (span_ready),
        .span_y     (span_y),
        .span_xa    (span_xa),
        .span_xb    (span_xb),
        .span_color (span_color),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_addr    (px_addr),
        .px_color   (px_color),
        .span_done  (span_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({span_ready, px_valid, span_done, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=1000",
                     {span_ready, px_valid, span_done, busy});
        end
        total++;
        if ({px_x, px_y, px_addr, px_color} !== 41'd0) begin
            bad++;
            $display("FAIL reset_data got x=%0d y=%0d a=%0d c=%0h exp 0",
                     px_x, px_y, px_addr, px_color);
        end
        rst = 1'b0;
        tick;
        total++;
        if ({span_ready, busy, px_valid} !== 3'b100) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=100",
                     {span_ready, busy, px_valid});
        end
    endtask

    task automatic test_basic;
        px_ready   = 1'b1;
        span_y     = 8'd10;
        span_xa    = 9'd5;
        span_xb    = 9'd8;
        span_color = 8'h3C;
        span_valid = 1'b1;
        tick;
        span_valid = 1'b0;
        total++;
        if ({busy, px_valid, span_ready} !== 3'b100) begin
            bad++;
            $display("FAIL basic_setup got=%b exp=100",
                     {busy, px_valid, span_ready});
        end
        tick;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (px_valid !== 1'b1 || span_done !== 1'b0 ||
                px_x !== 9'(5 + k) || px_addr !== 16'(3205 + k) ||
                px_y !== 8'd10 || px_color !== 8'h3C) begin
                bad++;
                $display("FAIL basic_px k=%0d got v=%b d=%b x=%0d a=%0d y=%0d c=%0h exp x=%0d a=%0d",
                         k, px_valid, span_done, px_x, px_addr, px_y,
                         px_color, 5 + k, 3205 + k);
            end
            tick;
        end
        total++;
        if ({span_done, span_ready, busy, px_valid} !== 4'b1100) begin
            bad++;
            $display("FAIL basic_done got=%b exp=1100",
                     {span_done, span_ready, busy, px_valid});
        end
        tick;
        total++;
        if (span_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse got=%b exp=0", span_done);
        end
    endtask

    task automatic test_swap;
        int   n;
        logic done;
        span_y     = 8'd0;
        span_xa    = 9'd300;
        span_xb    = 9'd297;
        span_color = 8'h11;
        span_valid = 1'b1;
        tick;
        span_valid = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick;
            if (span_done) begin
                done = 1'b1;
            end else if (px_valid) begin
                total++;
                if (px_x !== 9'(297 + n) || px_addr !== 16'(297 + n)) begin
                    bad++;
                    $display("FAIL swap_px n=%0d got x=%0d a=%0d exp %0d",
                             n, px_x, px_addr, 297 + n);
                end
                n++;
            end
        end
        total++;
        if (!done || n != 4) begin
            bad++;
            $display("FAIL swap_count got n=%0d done=%b exp n=4 done=1", n, done);
        end
    endtask

    task automatic test_clip;
        int          n;
        logic        done;
        logic [15:0] last;
        span_y     = 8'd199;
        span_xa    = 9'd310;
        span_xb    = 9'd400;
        span_color = 8'hA5;
        span_valid = 1'b1;
        tick;
        span_valid = 1'b0;
        n    = 0;
        done = 1'b0;
        last = '0;
        for (int c = 0; c < 30 && !done; c++) begin
            tick;
            if (span_done) begin
                done = 1'b1;
            end else if (px_valid) begin
                total++;
                if (px_x !== 9'(310 + n) || px_addr !== 16'(63990 + n)) begin
                    bad++;
                    $display("FAIL clip_px n=%0d got x=%0d a=%0d exp x=%0d a=%0d",
                             n, px_x, px_addr, 310 + n, 63990 + n);
                end
                last = px_addr;
                n++;
            end
        end
        total++;
        if (!done || n != 10 || last !== 16'd63999) begin
            bad++;
            $display("FAIL clip_count got n=%0d last=%0d done=%b exp n=10 last=63999",
                     n, last, done);
        end
    endtask

    task automatic test_empty;
        logic [7:0] ey [2] = '{8'd200, 8'd5};
        logic [8:0] ea [2] = '{9'd1, 9'd330};
        logic [8:0] eb [2] = '{9'd2, 9'd330};
        for (int t = 0; t < 2; t++) begin
            span_y     = ey[t];
            span_xa    = ea[t];
            span_xb    = eb[t];
            span_color = 8'h77;
            span_valid = 1'b1;
            tick;
            span_valid = 1'b0;
            total++;
            if ({busy, px_valid, span_done} !== 3'b100) begin
                bad++;
                $display("FAIL empty_setup t=%0d got=%b exp=100",
                         t, {busy, px_valid, span_done});
            end
            tick;
            total++;
            if ({span_done, px_valid, busy, span_ready} !== 4'b1001) begin
                bad++;
                $display("FAIL empty_done t=%0d got=%b exp=1001",
                         t, {span_done, px_valid, busy, span_ready});
            end
            tick;
            total++;
            if ({span_done, px_valid} !== 2'b00) begin
                bad++;
                $display("FAIL empty_after t=%0d got=%b exp=00",
                         t, {span_done, px_valid});
            end
        end
    endtask

    task automatic test_backpressure;
        px_ready   = 1'b0;
        span_y     = 8'd1;
        span_xa    = 9'd0;
        span_xb    = 9'd0;
        span_color = 8'h42;
        span_valid = 1'b1;
        tick;
        span_valid = 1'b0;
        tick;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (px_valid !== 1'b1 || px_addr !== 16'd320 || px_x !== 9'd0 ||
                px_y !== 8'd1 || px_color !== 8'h42 || span_done !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold k=%0d got v=%b a=%0d x=%0d y=%0d d=%b exp v=1 a=320",
                         k, px_valid, px_addr, px_x, px_y, span_done);
            end
            tick;
        end
        px_ready = 1'b1;
        tick;
        total++;
        if ({span_done, px_valid} !== 2'b10) begin
            bad++;
            $display("FAIL bp_done got=%b exp=10", {span_done, px_valid});
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int acc0;
        int acc1;
        px_ready   = 1'b1;
        span_y     = 8'd2;
        span_xa    = 9'd0;
        span_xb    = 9'd2;
        span_color = 8'h01;
        span_valid = 1'b1;
        acc0 = cyc;
        tick;
        span_y     = 8'd3;
        span_xa    = 9'd4;
        span_xb    = 9'd4;
        span_color = 8'h02;
        total++;
        if (span_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_setup_ready got=%b exp=0", span_ready);
        end
        tick;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (px_valid !== 1'b1 || px_x !== 9'(k) ||
                px_addr !== 16'(640 + k) || px_y !== 8'd2) begin
                bad++;
                $display("FAIL b2b_a k=%0d got v=%b x=%0d a=%0d y=%0d exp x=%0d a=%0d",
                         k, px_valid, px_x, px_addr, px_y, k, 640 + k);
            end
            tick;
        end
        acc1 = cyc;
        total++;
        if ({span_done, span_ready, busy} !== 3'b110 || acc1 - acc0 != 5) begin
            bad++;
            $display("FAIL b2b_accept got=%b period=%0d exp=110 period=5",
                     {span_done, span_ready, busy}, acc1 - acc0);
        end
        tick;
        span_valid = 1'b0;
        total++;
        if ({busy, span_done, px_valid} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_setup2 got=%b exp=100", {busy, span_done, px_valid});
        end
        tick;
        total++;
        if (px_valid !== 1'b1 || px_x !== 9'd4 || px_addr !== 16'd964 ||
            px_y !== 8'd3 || px_color !== 8'h02) begin
            bad++;
            $display("FAIL b2b_b got v=%b x=%0d a=%0d y=%0d c=%0h exp x=4 a=964 y=3",
                     px_valid, px_x, px_addr, px_y, px_color);
        end
        tick;
        total++;
        if ({span_done, px_valid} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_done got=%b exp=10", {span_done, px_valid});
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int   n;
        logic done;
        px_ready   = 1'b1;
        span_y     = 8'd7;
        span_xa    = 9'd0;
        span_xb    = 9'd100;
        span_color = 8'hEE;
        span_valid = 1'b1;
        tick;
        span_valid = 1'b0;
        tick;
        repeat (50) tick;
        total++;
        if (px_valid !== 1'b1 || px_x !== 9'd50 || px_addr !== 16'd2290) begin
            bad++;
            $display("FAIL rstmid_pos got v=%b x=%0d a=%0d exp v=1 x=50 a=2290",
                     px_valid, px_x, px_addr);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({px_valid, busy, span_done, span_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_async got=%b exp=0001",
                     {px_valid, busy, span_done, span_ready});
        end
        tick;
        rst = 1'b0;
        tick;
        total++;
        if ({span_done, px_valid} !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_nodone got=%b exp=00", {span_done, px_valid});
        end
        span_y     = 8'd4;
        span_xa    = 9'd3;
        span_xb    = 9'd2;
        span_color = 8'h99;
        span_valid = 1'b1;
        tick;
        span_valid = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            tick;
            if (span_done) begin
                done = 1'b1;
            end else if (px_valid) begin
                total++;
                if (px_x !== 9'(2 + n) || px_addr !== 16'(1282 + n) ||
                    px_color !== 8'h99) begin
                    bad++;
                    $display("FAIL rstmid_next n=%0d got x=%0d a=%0d c=%0h exp x=%0d a=%0d",
                             n, px_x, px_addr, px_color, 2 + n, 1282 + n);
                end
                n++;
            end
        end
        total++;
        if (!done || n != 2) begin
            bad++;
            $display("FAIL rstmid_count got n=%0d done=%b exp n=2 done=1", n, done);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        span_valid = 1'b0;
        span_y     = '0;
        span_xa    = '0;
        span_xb    = '0;
        span_color = '0;
        px_ready   = 1'b1;
        test_reset;
        test_basic;
        test_swap;
        test_clip;
        test_empty;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
